// File: rtl/vector_wb_demux_if.sv
// Bus bundle for vector_wb_demux: result-vector input, VRF write port and serial beat port.
// Optional lane-mask signals exist only when VECTOR_WB_DEMUX_LANE_MASK_EN is defined.
interface vector_wb_demux_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic              control;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] res1, res2, res3, res4, res5, res6, res7, res8;

  logic              vrf_we;
  logic [ADDR_W-1:0] vrf_waddr;
  logic [DATA_W-1:0] vrf_wdata1, vrf_wdata2, vrf_wdata3, vrf_wdata4;
  logic [DATA_W-1:0] vrf_wdata5, vrf_wdata6, vrf_wdata7, vrf_wdata8;

  logic              sout_valid;
  logic              sout_ready;
  logic [DATA_W-1:0] sout_data;
  logic [2:0]        sout_lane;
  logic              sout_last;

`ifdef VECTOR_WB_DEMUX_LANE_MASK_EN
  logic [7:0]        lane_mask;
  logic [7:0]        vrf_wmask;
`endif

  // Demux side
  modport slave (
    input  in_valid, control, in_addr,
    input  res1, res2, res3, res4, res5, res6, res7, res8,
    output in_ready,
    output vrf_we, vrf_waddr,
    output vrf_wdata1, vrf_wdata2, vrf_wdata3, vrf_wdata4,
    output vrf_wdata5, vrf_wdata6, vrf_wdata7, vrf_wdata8,
    output sout_valid, sout_data, sout_lane, sout_last,
    input  sout_ready
`ifdef VECTOR_WB_DEMUX_LANE_MASK_EN
    , input lane_mask
    , output vrf_wmask
`endif
  );

  // Producer / consumer side
  modport master (
    output in_valid, control, in_addr,
    output res1, res2, res3, res4, res5, res6, res7, res8,
    input  in_ready,
    input  vrf_we, vrf_waddr,
    input  vrf_wdata1, vrf_wdata2, vrf_wdata3, vrf_wdata4,
    input  vrf_wdata5, vrf_wdata6, vrf_wdata7, vrf_wdata8,
    input  sout_valid, sout_data, sout_lane, sout_last,
    output sout_ready
`ifdef VECTOR_WB_DEMUX_LANE_MASK_EN
    , output lane_mask
    , input vrf_wmask
`endif
  );
endinterface

// File: rtl/vector_wb_demux.sv
// Routes an 8-lane result vector either to the vector register file (one-cycle
// write pulse) or out of a serial port one lane per handshake.
// Optional feature macro: VECTOR_WB_DEMUX_LANE_MASK_EN adds lane_mask/vrf_wmask
// and restricts serial emission to the masked lanes.
module vector_wb_demux #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input logic             clk,
  input logic             rst,
  vector_wb_demux_if.slave bus
);
  localparam int unsigned LANES  = 8;
  localparam int unsigned LANE_W = 3;

  typedef enum logic {IDLE, SERIAL} state_t;

  state_t              state_q, state_d;
  logic [LANE_W-1:0]   ptr_q, ptr_d;
  logic [LANES-1:0]    mask_q, mask_d;
  logic [DATA_W-1:0]   buf_q [LANES];
  logic [DATA_W-1:0]   buf_d [LANES];
  logic [DATA_W-1:0]   sdata_q, sdata_d;
  logic                slast_q, slast_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q [LANES];
  logic [DATA_W-1:0]   wdata_d [LANES];
  logic [LANES-1:0]    wmask_q, wmask_d;
  logic [DATA_W-1:0]   lanes_in [LANES];
  logic [LANES-1:0]    in_mask;
  logic                accept;

  // Lowest set lane at or above lo (0 when none).
  function automatic logic [LANE_W-1:0] lowest_from(input logic [LANES-1:0] m, input int lo);
    logic [LANE_W-1:0] r;
    r = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (m[i] && i >= lo) r = LANE_W'(i);
    end
    return r;
  endfunction

  // Highest set lane (0 when none).
  function automatic logic [LANE_W-1:0] highest_set(input logic [LANES-1:0] m);
    logic [LANE_W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      if (m[i]) r = LANE_W'(i);
    end
    return r;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    lanes_in = '{bus.res1, bus.res2, bus.res3, bus.res4,
                 bus.res5, bus.res6, bus.res7, bus.res8};
`ifdef VECTOR_WB_DEMUX_LANE_MASK_EN
    in_mask  = bus.lane_mask;
`else
    in_mask  = '1;
`endif
    accept   = bus.in_valid && (state_q == IDLE);

    state_d  = state_q;
    ptr_d    = ptr_q;
    mask_d   = mask_q;
    buf_d    = buf_q;
    sdata_d  = sdata_q;
    slast_d  = slast_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!bus.control) begin
            we_d    = 1'b1;
            waddr_d = bus.in_addr;
            wdata_d = lanes_in;
            wmask_d = in_mask;
          end else if (in_mask != '0) begin
            // Empty mask drops the vector without leaving IDLE.
            state_d = SERIAL;
            buf_d   = lanes_in;
            mask_d  = in_mask;
            ptr_d   = lowest_from(in_mask, 0);
            sdata_d = lanes_in[ptr_d];
            slast_d = (ptr_d == highest_set(in_mask));
          end
        end
      end
      SERIAL: begin
        if (bus.sout_ready) begin
          if (slast_q) begin
            state_d = IDLE;
            ptr_d   = '0;
            slast_d = 1'b0;
          end else begin
            ptr_d   = lowest_from(mask_q, int'(ptr_q) + 1);
            sdata_d = buf_q[ptr_d];
            slast_d = (ptr_d == highest_set(mask_q));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      mask_q  <= '0;
      sdata_q <= '0;
      slast_q <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wmask_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        buf_q[i]   <= '0;
        wdata_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      sdata_q <= sdata_d;
      slast_q <= slast_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wmask_q <= wmask_d;
      buf_q   <= buf_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.sout_valid = (state_q == SERIAL);
  assign bus.sout_data  = sdata_q;
  assign bus.sout_lane  = ptr_q;
  assign bus.sout_last  = slast_q;
  assign bus.vrf_we     = we_q;
  assign bus.vrf_waddr  = waddr_q;
  assign bus.vrf_wdata1 = wdata_q[0];
  assign bus.vrf_wdata2 = wdata_q[1];
  assign bus.vrf_wdata3 = wdata_q[2];
  assign bus.vrf_wdata4 = wdata_q[3];
  assign bus.vrf_wdata5 = wdata_q[4];
  assign bus.vrf_wdata6 = wdata_q[5];
  assign bus.vrf_wdata7 = wdata_q[6];
  assign bus.vrf_wdata8 = wdata_q[7];
`ifdef VECTOR_WB_DEMUX_LANE_MASK_EN
  assign bus.vrf_wmask  = wmask_q;
`else
  // Mask register only feeds the optional output.
  logic unused_wmask;
  assign unused_wmask = ^wmask_q;
`endif
endmodule

// File: tb/tb_vector_wb_demux.sv
// Self-checking bench for vector_wb_demux; expected beats come from a lane-mask
// reference queue, expected VRF contents from a last-write model.
module tb_vector_wb_demux;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
`ifdef VECTOR_WB_DEMUX_LANE_MASK_EN
  localparam logic [7:0] FORCE_MASK = 8'h00;
`else
  localparam logic [7:0] FORCE_MASK = 8'hFF;
`endif

  typedef struct packed {
    logic [2:0]        lane;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vector_wb_demux_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  vector_wb_demux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  logic [7:0] drive_mask;
`ifdef VECTOR_WB_DEMUX_LANE_MASK_EN
  assign bus.lane_mask = drive_mask;
`endif

  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] lanes [8];
  logic [DATA_W-1:0] cap [8];
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_wdata [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] wdata_at(input int i);
    case (i)
      0: return bus.vrf_wdata1;
      1: return bus.vrf_wdata2;
      2: return bus.vrf_wdata3;
      3: return bus.vrf_wdata4;
      4: return bus.vrf_wdata5;
      5: return bus.vrf_wdata6;
      6: return bus.vrf_wdata7;
      default: return bus.vrf_wdata8;
    endcase
  endfunction

  task automatic drive_lanes();
    bus.res1 = lanes[0]; bus.res2 = lanes[1]; bus.res3 = lanes[2]; bus.res4 = lanes[3];
    bus.res5 = lanes[4]; bus.res6 = lanes[5]; bus.res7 = lanes[6]; bus.res8 = lanes[7];
  endtask

  task automatic randomize_lanes(input bit fixed, input logic [DATA_W-1:0] base);
    for (int i = 0; i < 8; i++) lanes[i] = fixed ? base + DATA_W'(i + 1) : DATA_W'($urandom);
    drive_lanes();
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.control = 1'b0; bus.in_addr = '0;
    bus.sout_ready = 1'b0; drive_mask = '0;
    for (int i = 0; i < 8; i++) lanes[i] = '0;
    drive_lanes();
  endtask

  task automatic check_vrf_hold(input string tag);
    tests++;
    if (bus.vrf_waddr !== last_addr) begin
      fails++; $display("FAIL %s_waddr_hold: got %h expected %h", tag, bus.vrf_waddr, last_addr);
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (wdata_at(i) !== last_wdata[i]) begin
        fails++; $display("FAIL %s_wdata_hold lane %0d: got %h expected %h", tag, i, wdata_at(i), last_wdata[i]);
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    tests++;
    if ({bus.in_ready, bus.vrf_we, bus.sout_valid, bus.sout_last, bus.sout_lane} !== 7'b1000000) begin
      fails++; $display("FAIL reset_ctrl: got %b expected %b",
        {bus.in_ready, bus.vrf_we, bus.sout_valid, bus.sout_last, bus.sout_lane}, 7'b1000000);
    end
    tests++;
    if (bus.sout_data !== '0) begin
      fails++; $display("FAIL reset_sout_data: got %h expected 0", bus.sout_data);
    end
`ifdef VECTOR_WB_DEMUX_LANE_MASK_EN
    tests++;
    if (bus.vrf_wmask !== 8'h00) begin
      fails++; $display("FAIL reset_wmask: got %h expected 00", bus.vrf_wmask);
    end
`endif
    last_addr = '0;
    for (int i = 0; i < 8; i++) last_wdata[i] = '0;
    check_vrf_hold("reset");
    rst = 1'b0;
    step();
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_vector_write(input logic [ADDR_W-1:0] addr, input bit fixed, input string tag);
    logic [7:0] m;
    randomize_lanes(fixed, '0);
    m = 8'($urandom);
    drive_mask = m;
    bus.control = 1'b0; bus.in_addr = addr; bus.in_valid = 1'b1;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL %s_ready_pre: got %b expected 1", tag, bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    tests++;
    if (bus.vrf_we !== 1'b1) begin
      fails++; $display("FAIL %s_we_pulse: got %b expected 1", tag, bus.vrf_we);
    end
    last_addr = addr;
    for (int i = 0; i < 8; i++) last_wdata[i] = lanes[i];
`ifdef VECTOR_WB_DEMUX_LANE_MASK_EN
    tests++;
    if (bus.vrf_wmask !== m) begin
      fails++; $display("FAIL %s_wmask: got %h expected %h", tag, bus.vrf_wmask, m);
    end
`endif
    // Scramble inputs: with in_valid low nothing may change.
    randomize_lanes(0, '0);
    bus.in_addr = ~addr;
    check_vrf_hold(tag);
    step();
    tests++;
    if ({bus.vrf_we, bus.in_ready} !== 2'b01) begin
      fails++; $display("FAIL %s_we_end: got we/ready %b expected 01", tag, {bus.vrf_we, bus.in_ready});
    end
    check_vrf_hold({tag, "_after"});
  endtask

  task automatic accept_serial(input logic [7:0] mask, input bit fixed, input logic [DATA_W-1:0] base);
    randomize_lanes(fixed, base);
    for (int i = 0; i < 8; i++) cap[i] = lanes[i];
    bus.control = 1'b1; bus.in_addr = ADDR_W'($urandom); drive_mask = mask; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Observe a burst that was accepted at the previous edge; mode 0 ready=1,
  // mode 1 ready 1,0,0 repeating, mode 2 random. junk drives garbage offers.
  task automatic run_burst(input logic [7:0] mask, input int mode, input bit junk,
                           input int stop_after, input string tag);
    beat_t exp[$];
    beat_t got[$];
    beat_t prev;
    beat_t cur;
    logic [7:0] m;
    int hi;
    int cyc;
    bit prev_stall;
    bit side_ok;
    bit stable_ok;
    bit rdy;
    m = mask | FORCE_MASK;
    hi = -1;
    for (int i = 0; i < 8; i++) if (m[i]) hi = i;
    for (int i = 0; i < 8; i++) if (m[i]) exp.push_back('{lane: 3'(i), data: cap[i], last: (i == hi)});
    cyc = 0; prev_stall = 0; side_ok = 1; stable_ok = 1; prev = '0;
    tests++;
    if ({bus.sout_valid, bus.vrf_we} !== {(m != 8'h00), 1'b0}) begin
      fails++; $display("FAIL %s_first_beat: got valid/we %b expected %b", tag,
        {bus.sout_valid, bus.vrf_we}, {(m != 8'h00), 1'b0});
    end
    while (bus.sout_valid === 1'b1 && cyc < 200) begin
      cur = '{lane: bus.sout_lane, data: bus.sout_data, last: bus.sout_last};
      if (prev_stall && cur !== prev) stable_ok = 0;
      if (bus.in_ready !== 1'b0 || bus.vrf_we !== 1'b0) side_ok = 0;
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      bus.sout_ready = rdy;
      if (junk) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.control = 1'($urandom_range(0, 1));
        bus.in_addr = ADDR_W'($urandom);
        drive_mask = 8'($urandom);
        randomize_lanes(0, '0);
      end
      if (rdy) got.push_back(cur);
      prev = cur; prev_stall = !rdy; cyc++;
      step();
      if (stop_after != 0 && got.size() == stop_after) break;
    end
    bus.sout_ready = 1'b0;
    if (junk) bus.in_valid = 1'b0;
    if (stop_after == 0) begin
      tests++;
      if (bus.sout_valid !== 1'b0) begin
        fails++; $display("FAIL %s_timeout: got sout_valid %b after %0d cycles expected 0", tag, bus.sout_valid, cyc);
      end
      tests++;
      if (bus.in_ready !== 1'b1) begin
        fails++; $display("FAIL %s_ready_after: got %b expected 1", tag, bus.in_ready);
      end
      tests++;
      if (got.size() != exp.size()) begin
        fails++; $display("FAIL %s_beat_count: got %0d expected %0d", tag, got.size(), exp.size());
      end
      tests++;
      if (!side_ok) begin
        fails++; $display("FAIL %s_busy_side: got in_ready/vrf_we active during burst expected 0", tag);
      end
      tests++;
      if (!stable_ok) begin
        fails++; $display("FAIL %s_stall_stable: got beat change while stalled expected held", tag);
      end
      if (mode == 0) begin
        tests++;
        if (cyc != exp.size()) begin
          fails++; $display("FAIL %s_burst_cycles: got %0d expected %0d", tag, cyc, exp.size());
        end
      end
    end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      tests++;
      if (got[i] !== exp[i]) begin
        fails++; $display("FAIL %s_beat%0d: got lane %0d data %h last %b expected lane %0d data %h last %b",
          tag, i, got[i].lane, got[i].data, got[i].last, exp[i].lane, exp[i].data, exp[i].last);
      end
    end
  endtask

  task automatic test_vector_writes();
    test_vector_write(4'd5, 1'b1, "vwrite5");
    test_vector_write(4'd0, 1'b0, "vwrite0");
    test_vector_write(4'd15, 1'b0, "vwrite15");
  endtask

  task automatic test_serial_burst();
    accept_serial(8'hFF, 1'b1, 32'h100);
    run_burst(8'hFF, 0, 1'b0, 0, "burst");
    check_vrf_hold("burst");
  endtask

  task automatic test_backpressure();
    accept_serial(8'hFF, 1'b0, '0);
    run_burst(8'hFF, 1, 1'b1, 0, "bp_pattern");
    accept_serial(8'hFF, 1'b0, '0);
    run_burst(8'hFF, 2, 1'b1, 0, "bp_random");
    check_vrf_hold("bp");
  endtask

  task automatic test_reset_mid_burst();
    int leaked;
    accept_serial(8'hFF, 1'b1, 32'h200);
    run_burst(8'hFF, 0, 1'b0, 3, "rst_mid");
    rst = 1'b1;
    bus.sout_ready = 1'b1;
    step();
    tests++;
    if ({bus.in_ready, bus.vrf_we, bus.sout_valid, bus.sout_last, bus.sout_lane} !== 7'b1000000) begin
      fails++; $display("FAIL rst_mid_ctrl: got %b expected %b",
        {bus.in_ready, bus.vrf_we, bus.sout_valid, bus.sout_last, bus.sout_lane}, 7'b1000000);
    end
    tests++;
    if (bus.sout_data !== '0) begin
      fails++; $display("FAIL rst_mid_data: got %h expected 0", bus.sout_data);
    end
    rst = 1'b0;
    bus.sout_ready = 1'b1;
    leaked = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.sout_valid !== 1'b0 || bus.in_ready !== 1'b1) leaked++;
      step();
    end
    bus.sout_ready = 1'b0;
    tests++;
    if (leaked != 0) begin
      fails++; $display("FAIL rst_mid_no_beats: got %0d busy cycles expected 0", leaked);
    end
    // A vector write accepted in the reset cycle is cancelled.
    randomize_lanes(0, '0);
    bus.control = 1'b0; bus.in_addr = 4'd7; bus.in_valid = 1'b1; rst = 1'b1;
    step();
    bus.in_valid = 1'b0; rst = 1'b0;
    tests++;
    if (bus.vrf_we !== 1'b0) begin
      fails++; $display("FAIL rst_we_override: got %b expected 0", bus.vrf_we);
    end
    last_addr = '0;
    for (int i = 0; i < 8; i++) last_wdata[i] = '0;
    check_vrf_hold("rst_mid");
  endtask

  task automatic test_mask();
    accept_serial(8'b1010_0100, 1'b0, '0);
    run_burst(8'b1010_0100, 0, 1'b0, 0, "mask_a4");
    accept_serial(8'h00, 1'b0, '0);
    run_burst(8'h00, 0, 1'b0, 0, "mask_zero");
    accept_serial(8'h01, 1'b0, '0);
    run_burst(8'h01, 1, 1'b0, 0, "mask_01");
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] a [8];
    randomize_lanes(0, '0);
    bus.control = 1'b0; bus.in_addr = 4'd3; bus.in_valid = 1'b1; drive_mask = 8'hFF;
    for (int i = 0; i < 8; i++) a[i] = lanes[i];
    step();
    randomize_lanes(0, '0);
    bus.in_addr = 4'd9;
    tests++;
    if ({bus.vrf_we, bus.vrf_waddr, bus.vrf_wdata4} !== {1'b1, 4'd3, a[3]}) begin
      fails++; $display("FAIL b2b_first: got %h expected %h",
        {bus.vrf_we, bus.vrf_waddr, bus.vrf_wdata4}, {1'b1, 4'd3, a[3]});
    end
    step();
    last_addr = 4'd9;
    for (int i = 0; i < 8; i++) last_wdata[i] = lanes[i];
    tests++;
    if (bus.vrf_we !== 1'b1) begin
      fails++; $display("FAIL b2b_second_we: got %b expected 1", bus.vrf_we);
    end
    check_vrf_hold("b2b_second");
    randomize_lanes(0, '0);
    for (int i = 0; i < 8; i++) cap[i] = lanes[i];
    bus.control = 1'b1;
    step();
    // Next serial offer stays presented during the running burst.
    randomize_lanes(0, '0);
    run_burst(8'hFF, 0, 1'b0, 0, "b2b_c");
    for (int i = 0; i < 8; i++) cap[i] = lanes[i];
    step();
    bus.in_valid = 1'b0;
    run_burst(8'hFF, 2, 1'b0, 0, "b2b_d");
    check_vrf_hold("b2b_end");
  endtask

  task automatic test_random();
    logic [7:0] m;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        test_vector_write(ADDR_W'($urandom), 1'b0, "rnd_vwrite");
      end else begin
        m = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        accept_serial(m, 1'b0, '0);
        run_burst(m, 2, 1'b1, 0, "rnd_burst");
        check_vrf_hold("rnd_burst");
      end
    end
  endtask

  initial begin
    test_reset();
    test_vector_writes();
    test_serial_burst();
    test_backpressure();
    test_reset_mid_burst();
    test_mask();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/vector_wb_demux.md
VECTOR_WB_DEMUX -- requirements
Module: vector_wb_demux

Interface
REQ-001 SHALL have parameter DATA_W, default 32, lane data width.
REQ-002 SHALL have parameter ADDR_W, default 4, vector register address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, a result vector is offered.
REQ-006 SHALL have port in_ready, output, 1, the block can accept a result vector.
REQ-007 SHALL have port control, input, 1, destination select: 0 means vector register file, 1 means serial port; sampled on accept.
REQ-008 SHALL have port in_addr, input, ADDR_W, destination vector register.
REQ-009 SHALL have ports res1..res8, input, DATA_W each, lane results.
REQ-010 SHALL have port vrf_we, output, 1, vector register file write strobe.
REQ-011 SHALL have port vrf_waddr, output, ADDR_W, write address.
REQ-012 SHALL have ports vrf_wdata1..vrf_wdata8, output, DATA_W each, write data.
REQ-013 SHALL have port sout_valid, output, 1, serial beat valid.
REQ-014 SHALL have port sout_ready, input, 1, serial consumer ready.
REQ-015 SHALL have port sout_data, output, DATA_W, serial beat data.
REQ-016 SHALL have port sout_lane, output, 3, lane index of the current beat.
REQ-017 SHALL have port sout_last, output, 1, marks the final beat of the vector.

Function
REQ-018 SHALL define accept as in_valid && in_ready; in_ready SHALL be 1 exactly when the state is IDLE.
REQ-019 SHALL use FSM states IDLE and SERIAL.
REQ-020 On accept with control=0, SHALL register all lanes and the address and pulse vrf_we high for exactly one cycle, the cycle after accept; state SHALL remain IDLE, so back-to-back accepts give consecutive vrf_we pulses.
REQ-021 vrf_waddr and vrf_wdata* SHALL hold their last written values while vrf_we is 0.
REQ-022 On accept with control=1, SHALL capture all 8 lanes into an internal buffer, set the lane pointer to the first emitted lane, and enter SERIAL.
REQ-023 In SERIAL, SHALL drive sout_valid=1, sout_data=buffer[ptr], sout_lane=ptr; data SHALL be held stable until the handshake sout_valid && sout_ready.
REQ-024 On each handshake, SHALL advance to the next emitted lane, in ascending lane order.
REQ-025 SHALL assert sout_last only on the final emitted lane.
REQ-026 On the handshake of the last beat, SHALL return to IDLE; in_ready SHALL rise the following cycle, with no same-cycle re-accept.
REQ-027 Unmasked serial latency SHALL be: first beat valid 1 cycle after accept, minimum 8 cycles for the full burst with sout_ready tied to 1.
REQ-028 sout_valid SHALL be 0 in IDLE, and vrf_we SHALL be 0 in SERIAL.
REQ-029 Input changes SHALL have no effect while in_ready=0.

Reset
REQ-030 On rst, SHALL force state IDLE, vrf_we=0, vrf_waddr=0, vrf_wdata*=0, sout_valid=0, sout_data=0, sout_lane=0, sout_last=0, lane pointer=0.
REQ-031 rst SHALL override any in-progress serial burst (remaining beats are dropped) and any pending vrf_we pulse; in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-032 When macro VECTOR_WB_DEMUX_LANE_MASK_EN is defined, SHALL add input lane_mask[7:0], captured on accept, and output vrf_wmask[7:0], registered alongside vrf_we and reset to 0.
REQ-033 With the macro defined, the serial path SHALL emit only lanes whose mask bit is 1, and sout_last SHALL mark the highest set bit.
REQ-034 With the macro defined, a serial accept with lane_mask=0 SHALL produce no beats and SHALL keep the state in IDLE.
REQ-035 Without the macro, neither port SHALL exist and all 8 lanes SHALL always be written and emitted.

Verification
REQ-036 Vector write: control=0, in_addr=5, resN=N; required: vrf_we pulses 1 cycle later with waddr=5 and wdataN=N, and in_ready stays 1.
REQ-037 Serial burst: control=1, resN=0x100+N, sout_ready=1; required: 8 beats, lanes 0..7, data 0x101..0x108, sout_last only on lane 7, in_ready=1 the cycle after.
REQ-038 Backpressure: sout_ready toggles 1,0,0,1,... during a burst; required: data and lane held stable while stalled, no beat lost or duplicated.
REQ-039 Reset mid-burst: rst asserted after beat 3; required: all outputs at reset values next cycle, in_ready=1, and no further beats.
REQ-040 Mask (macro defined): lane_mask=8'b1010_0100, control=1; required: beats for lanes 2, 5, 7 only, with last on lane 7; then lane_mask=0 gives no beats and in_ready stays 1.
REQ-041 Back-to-back: two control=0 accepts, then a control=1 accept presented during the burst; required: two consecutive vrf_we pulses, and in_ready=0 until the burst completes.
